// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter: owns both ports of the 4 KB Chip-8 memory and shares
// them between the host (fixed priority), CPU fetch and CPU data (round-robin).
// Multi-beat data bursts are sequenced internally by a two-state FSM.
// Optional build macro: CHIP8_ARB_PROTECT_EN suppresses data-port writes below
// 0x200 and raises a sticky data_err; when undefined data_err is tied low.
module chip8_mem_arbiter #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cpu_en,
    input  logic                host_req,
    input  logic                host_we,
    input  logic [ADDR_W-1:0]   host_addr,
    input  logic [DATA_W-1:0]   host_wdata,
    output logic                host_gnt,
    output logic                host_rvalid,
    output logic [DATA_W-1:0]   host_rdata,
    input  logic                fetch_req,
    input  logic [ADDR_W-1:0]   fetch_addr,
    output logic                fetch_gnt,
    output logic                fetch_valid,
    output logic [15:0]         fetch_instr,
    input  logic                data_req,
    input  logic                data_we,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [3:0]          data_len,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_gnt,
    output logic [3:0]          data_beat,
    output logic                data_last,
    output logic                data_rvalid,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_err,
    output logic [ADDR_W-1:0]   mem_addr1,
    output logic [ADDR_W-1:0]   mem_addr2,
    output logic                mem_we1,
    output logic                mem_we2,
    output logic [DATA_W-1:0]   mem_wdata1,
    output logic [DATA_W-1:0]   mem_wdata2,
    input  logic [DATA_W-1:0]   mem_rdata1,
    input  logic [DATA_W-1:0]   mem_rdata2
);

    localparam int unsigned BEAT_W = 4;
`ifdef CHIP8_ARB_PROTECT_EN
    localparam logic [ADDR_W-1:0] PROT_LIMIT = ADDR_W'(512);
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [BEAT_W-1:0]   len_q, len_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                we_q, we_d;
    logic                rr_q, rr_d;
    logic                host_rd_q, host_rd_d;
    logic                fetch_q, fetch_d;
    logic                data_rd_q, data_rd_d;
    logic                pick_fetch;
    logic [ADDR_W-1:0]   data_acc_addr;
    logic                data_acc_we;
    logic                data_acc_en;
`ifdef CHIP8_ARB_PROTECT_EN
    logic                err_q, err_d;
`endif

    // State, burst context, round-robin flag and read-owner tags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            we_q      <= 1'b0;
            rr_q      <= 1'b0;
            host_rd_q <= 1'b0;
            fetch_q   <= 1'b0;
            data_rd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            we_q      <= we_d;
            rr_q      <= rr_d;
            host_rd_q <= host_rd_d;
            fetch_q   <= fetch_d;
            data_rd_q <= data_rd_d;
        end
    end

`ifdef CHIP8_ARB_PROTECT_EN
    // Sticky protect-violation flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    // Arbitration, burst sequencing and memory-port steering
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        len_d         = len_q;
        beat_d        = beat_q;
        we_d          = we_q;
        rr_d          = rr_q;
        host_rd_d     = 1'b0;
        fetch_d       = 1'b0;
        data_rd_d     = 1'b0;
        host_gnt      = 1'b0;
        fetch_gnt     = 1'b0;
        data_gnt      = 1'b0;
        data_beat     = '0;
        data_last     = 1'b0;
        mem_addr1     = '0;
        mem_addr2     = '0;
        mem_we1       = 1'b0;
        mem_we2       = 1'b0;
        mem_wdata1    = '0;
        mem_wdata2    = '0;
        pick_fetch    = 1'b0;
        data_acc_addr = '0;
        data_acc_we   = 1'b0;
        data_acc_en   = 1'b0;
`ifdef CHIP8_ARB_PROTECT_EN
        err_d         = err_q;
`endif

        // Grants are gated by reset so the pins fall the instant reset asserts
        if (reset_n) begin
            case (state_q)
                IDLE: begin
                    if (host_req) begin
                        host_gnt   = 1'b1;
                        mem_addr1  = host_addr;
                        mem_we1    = host_we;
                        mem_wdata1 = host_wdata;
                        host_rd_d  = !host_we;
                    end else if (cpu_en && (fetch_req || data_req)) begin
                        // rr_q = 1 means data is owed the next contested grant
                        pick_fetch = fetch_req && (!data_req || !rr_q);
                        if (pick_fetch) begin
                            fetch_gnt = 1'b1;
                            mem_addr1 = fetch_addr;
                            mem_addr2 = fetch_addr + ADDR_W'(1);
                            fetch_d   = 1'b1;
                            rr_d      = 1'b1;
                        end else begin
                            data_gnt      = 1'b1;
                            data_beat     = '0;
                            data_acc_en   = 1'b1;
                            data_acc_addr = data_addr;
                            data_acc_we   = data_we;
                            rr_d          = 1'b0;
                            if (data_len == '0) begin
                                data_last = 1'b1;
                            end else begin
                                state_d = BURST;
                                base_d  = data_addr;
                                len_d   = data_len;
                                beat_d  = BEAT_W'(1);
                                we_d    = data_we;
                            end
                        end
                    end
                end
                BURST: begin
                    data_gnt      = 1'b1;
                    data_beat     = beat_q;
                    data_acc_en   = 1'b1;
                    data_acc_addr = base_q + ADDR_W'(beat_q);
                    data_acc_we   = we_q;
                    rr_d          = 1'b0;
                    if (beat_q == len_q) begin
                        data_last = 1'b1;
                        state_d   = IDLE;
                        beat_d    = '0;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // Data-path beat drives port 1; protected writes are dropped but still counted
            if (data_acc_en) begin
                mem_addr1  = data_acc_addr;
                mem_wdata1 = data_wdata;
                mem_we1    = data_acc_we;
                data_rd_d  = !data_acc_we;
`ifdef CHIP8_ARB_PROTECT_EN
                if (data_acc_we && (data_acc_addr < PROT_LIMIT)) begin
                    mem_we1 = 1'b0;
                    err_d   = 1'b1;
                end
`endif
            end
        end
    end

    // Read return routed by the owner tag registered at grant time
    assign host_rvalid = host_rd_q;
    assign host_rdata  = host_rd_q ? mem_rdata1 : '0;
    assign data_rvalid = data_rd_q;
    assign data_rdata  = data_rd_q ? mem_rdata1 : '0;
    assign fetch_valid = fetch_q;
    assign fetch_instr = fetch_q ? 16'({mem_rdata1, mem_rdata2}) : 16'h0000;

`ifdef CHIP8_ARB_PROTECT_EN
    assign data_err = err_q;
`else
    assign data_err = 1'b0;
`endif

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Scoreboard bench for chip8_mem_arbiter: directed stimulus pushes expected
// read data into per-requester queues; a negedge monitor pops and compares.
module tb_chip8_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_en;
    logic        host_req, host_we;
    logic [11:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_gnt, host_rvalid;
    logic [7:0]  host_rdata;
    logic        fetch_req;
    logic [11:0] fetch_addr;
    logic        fetch_gnt, fetch_valid;
    logic [15:0] fetch_instr;
    logic        data_req, data_we;
    logic [11:0] data_addr;
    logic [3:0]  data_len;
    logic [7:0]  data_wdata;
    logic        data_gnt;
    logic [3:0]  data_beat;
    logic        data_last, data_rvalid;
    logic [7:0]  data_rdata;
    logic        data_err;
    logic [11:0] mem_addr1, mem_addr2;
    logic        mem_we1, mem_we2;
    logic [7:0]  mem_wdata1, mem_wdata2;
    logic [7:0]  mem_rdata1 = 8'h00;
    logic [7:0]  mem_rdata2 = 8'h00;

    logic [7:0]  mem [4096];

    int tests = 0;
    int fails = 0;

    logic [7:0]  host_q  [$];
    logic [15:0] fetch_q [$];
    logic [7:0]  data_q  [$];

    chip8_mem_arbiter #(.ADDR_W(12), .DATA_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_en(cpu_en),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_len(data_len), .data_wdata(data_wdata), .data_gnt(data_gnt),
        .data_beat(data_beat), .data_last(data_last), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata), .data_err(data_err),
        .mem_addr1(mem_addr1), .mem_addr2(mem_addr2), .mem_we1(mem_we1),
        .mem_we2(mem_we2), .mem_wdata1(mem_wdata1), .mem_wdata2(mem_wdata2),
        .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2)
    );

    always #5 clk = ~clk;

    // Dual-port synchronous RAM model
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    end
    always @(posedge clk) begin
        if (mem_we1) mem[mem_addr1] <= mem_wdata1;
        if (mem_we2) mem[mem_addr2] <= mem_wdata2;
        mem_rdata1 <= mem[mem_addr1];
        mem_rdata2 <= mem[mem_addr2];
    end

    function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: no grant within cycle budget at %0t", name, $time);
    endfunction

    // Monitor: every valid pulse must match the oldest expectation
    always @(negedge clk) begin
        if (host_rvalid) begin
            if (host_q.size() == 0) timeout("host_rvalid_unexpected");
            else chk("host_rdata", 16'(host_rdata), 16'(host_q.pop_front()));
        end
        if (fetch_valid) begin
            if (fetch_q.size() == 0) timeout("fetch_valid_unexpected");
            else chk("fetch_instr", fetch_instr, fetch_q.pop_front());
        end
        if (data_rvalid) begin
            if (data_q.size() == 0) timeout("data_rvalid_unexpected");
            else chk("data_rdata", 16'(data_rdata), 16'(data_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_access(input logic we, input logic [11:0] addr,
                               input logic [7:0] wd, input logic [7:0] exp);
        bit got;
        got = 0;
        host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (host_gnt) begin
                got = 1;
                chk("host_mem_addr1", 16'(mem_addr1), 16'(addr));
                chk("host_mem_we1", 16'(mem_we1), 16'(we));
                if (we) chk("host_mem_wdata1", 16'(mem_wdata1), 16'(wd));
                else host_q.push_back(exp);
            end
        end
        if (!got) timeout("host_gnt");
        step();
        host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic fetch_access(input logic [11:0] addr, input logic [15:0] exp);
        bit got;
        logic [11:0] a2;
        got = 0;
        a2 = addr + 12'd1;
        fetch_req = 1'b1; fetch_addr = addr;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (fetch_gnt) begin
                got = 1;
                chk("fetch_mem_addr1", 16'(mem_addr1), 16'(addr));
                chk("fetch_mem_addr2", 16'(mem_addr2), 16'(a2));
                chk("fetch_no_write", 16'({mem_we1, mem_we2}), 16'h0);
                fetch_q.push_back(exp);
            end
        end
        if (!got) timeout("fetch_gnt");
        step();
        fetch_req = 1'b0;
    endtask

    // Data burst; bytes holds write data or expected read data, beat b in [8b+:8]
    task automatic data_burst(input logic we, input logic [11:0] addr, input logic [3:0] len,
                              input logic [127:0] bytes, input logic exp_we1,
                              input int hb, input logic [11:0] haddr, input logic [7:0] hexp);
        bit got;
        logic [11:0] a;
        logic [7:0]  bv;
        got = 0;
        data_req = 1'b1; data_we = we; data_addr = addr; data_len = len;
        data_wdata = bytes[7:0];
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (data_gnt) got = 1;
        end
        if (!got) begin
            timeout("data_gnt");
            step();
            data_req = 1'b0;
            return;
        end
        for (int b = 0; b <= int'(len); b++) begin
            if (b > 0) @(negedge clk);
            a  = addr + 12'(b);
            bv = bytes[8*b +: 8];
            chk("data_gnt", 16'(data_gnt), 16'h1);
            chk("data_beat", 16'(data_beat), 16'(b));
            chk("data_last", 16'(data_last), 16'(b == int'(len)));
            chk("data_mem_addr1", 16'(mem_addr1), 16'(a));
            chk("data_mem_we1", 16'(mem_we1), 16'(exp_we1));
            if (we) chk("data_mem_wdata1", 16'(mem_wdata1), 16'(bv));
            else data_q.push_back(bv);
            if (b > 0) chk("burst_blocks_others", 16'({host_gnt, fetch_gnt}), 16'h0);
            step();
            if (b == int'(len)) begin
                data_req = 1'b0; data_we = 1'b0;
            end else begin
                data_wdata = bytes[8*(b+1) +: 8];
                if (b + 1 == hb) begin
                    host_req = 1'b1; host_we = 1'b0; host_addr = haddr;
                end
            end
        end
        if (hb >= 0) begin
            @(negedge clk);
            chk("host_after_last", 16'(host_gnt), 16'h1);
            if (host_gnt) host_q.push_back(hexp);
            step();
            host_req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish at %0t", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        reset_n = 1'b0; cpu_en = 1'b1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 12'h000; host_wdata = 8'h00;
        fetch_req = 1'b1; fetch_addr = 12'h200;
        data_req = 1'b1; data_we = 1'b0; data_addr = 12'h210; data_len = 4'd0;
        data_wdata = 8'h00;

        // Reset: all requests pending, nothing granted
        @(negedge clk);
        chk("rst_gnts", 16'({host_gnt, fetch_gnt, data_gnt}), 16'h0);
        chk("rst_valids", 16'({host_rvalid, fetch_valid, data_rvalid}), 16'h0);
        chk("rst_we_last_err", 16'({mem_we1, mem_we2, data_last, data_err}), 16'h0);
        chk("rst_beat", 16'(data_beat), 16'h0);
        step();
        reset_n = 1'b1;

        // Arbitration from reset: host, fetch, data (memory all zero)
        @(negedge clk);
        chk("arb0_gnts", 16'({host_gnt, fetch_gnt, data_gnt}), 16'b100);
        host_q.push_back(8'h00);
        step(); host_req = 1'b0;
        @(negedge clk);
        chk("arb1_gnts", 16'({host_gnt, fetch_gnt, data_gnt}), 16'b010);
        fetch_q.push_back(16'h0000);
        step(); fetch_req = 1'b0;
        @(negedge clk);
        chk("arb2_gnts", 16'({host_gnt, fetch_gnt, data_gnt}), 16'b001);
        chk("arb2_last", 16'(data_last), 16'h1);
        data_q.push_back(8'h00);
        step(); data_req = 1'b0;

        // Host load then fetch
        host_access(1'b1, 12'h200, 8'hA2, 8'h00);
        host_access(1'b1, 12'h201, 8'h2A, 8'h00);
        fetch_access(12'h200, 16'hA22A);

        // Address wrap on fetch and on a data burst
        host_access(1'b1, 12'hFFF, 8'h5C, 8'h00);
        host_access(1'b1, 12'h000, 8'h7D, 8'h00);
        fetch_access(12'hFFF, 16'h5C7D);
        data_burst(1'b0, 12'hFFE, 4'd2, 128'h7D_5C_00, 1'b0, -1, 12'h000, 8'h00);

        // Fetch/data contention alternates, fetch first since data won last
        fetch_req = 1'b1; fetch_addr = 12'h200;
        data_req = 1'b1; data_we = 1'b0; data_addr = 12'h201; data_len = 4'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("alt_gnts", 16'({fetch_gnt, data_gnt}), (i % 2 == 0) ? 16'b10 : 16'b01);
            if (fetch_gnt) fetch_q.push_back(16'hA22A);
            if (data_gnt)  data_q.push_back(8'h2A);
            step();
        end
        fetch_req = 1'b0; data_req = 1'b0;

        // cpu_en low: only the host is served, pins idle otherwise
        cpu_en = 1'b0;
        fetch_req = 1'b1; data_req = 1'b1; data_addr = 12'h201;
        host_req = 1'b1; host_we = 1'b0; host_addr = 12'h201;
        @(negedge clk);
        chk("cpuoff_host", 16'({host_gnt, fetch_gnt, data_gnt}), 16'b100);
        host_q.push_back(8'h2A);
        step(); host_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("cpuoff_idle_gnts", 16'({host_gnt, fetch_gnt, data_gnt}), 16'h0);
            chk("cpuoff_idle_pins", 16'({mem_we1, mem_addr1}), 16'h0);
            step();
        end
        fetch_req = 1'b0; data_req = 1'b0; cpu_en = 1'b1;

        // Burst write with host raised at beat 1, then burst readback
        data_burst(1'b1, 12'h300, 4'd3, 128'h44_33_22_11, 1'b1, 1, 12'h301, 8'h22);
        data_burst(1'b0, 12'h300, 4'd3, 128'h44_33_22_11, 1'b0, -1, 12'h000, 8'h00);

        // Host write followed immediately by a data read of the same byte
        host_access(1'b1, 12'h500, 8'h3C, 8'h00);
        data_burst(1'b0, 12'h500, 4'd0, 128'h3C, 1'b0, -1, 12'h000, 8'h00);

        // Protect region write
        host_access(1'b1, 12'h1F0, 8'h99, 8'h00);
`ifdef CHIP8_ARB_PROTECT_EN
        data_burst(1'b1, 12'h1F0, 4'd0, 128'h55, 1'b0, -1, 12'h000, 8'h00);
        chk("protect_err", 16'(data_err), 16'h1);
        host_access(1'b0, 12'h1F0, 8'h00, 8'h99);
        host_access(1'b1, 12'h1F0, 8'h66, 8'h00);
        host_access(1'b0, 12'h1F0, 8'h00, 8'h66);
        chk("protect_err_sticky", 16'(data_err), 16'h1);
`else
        data_burst(1'b1, 12'h1F0, 4'd0, 128'h55, 1'b1, -1, 12'h000, 8'h00);
        chk("noprotect_err", 16'(data_err), 16'h0);
        host_access(1'b0, 12'h1F0, 8'h00, 8'h55);
`endif

        // Reset mid-burst with a read in flight
        data_req = 1'b1; data_we = 1'b0; data_addr = 12'h300; data_len = 4'd7;
        @(negedge clk);
        chk("rstb_beat0", 16'({data_gnt, data_beat}), 16'h10);
        data_q.push_back(8'h11);
        @(negedge clk);
        chk("rstb_beat1", 16'({data_gnt, data_beat}), 16'h11);
        chk("rstb_rvalid_before", 16'(data_rvalid), 16'h1);
        #2;
        reset_n = 1'b0;
        data_q.delete();
        #1;
        chk("rstb_gnts", 16'({host_gnt, fetch_gnt, data_gnt}), 16'h0);
        chk("rstb_rvalid_after", 16'(data_rvalid), 16'h0);
        chk("rstb_pins", 16'({mem_we1, mem_addr1}), 16'h0);
        chk("rstb_last_beat_err", 16'({data_last, data_beat, data_err}), 16'h0);
        step();
        data_req = 1'b0;
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_beat", 16'(data_beat), 16'h0);
        chk("post_rst_idle", 16'({data_gnt, data_rvalid}), 16'h0);
        step();
        fetch_access(12'h200, 16'hA22A);

        repeat (3) step();
        chk("host_q_left", 16'(host_q.size()), 16'h0);
        chk("fetch_q_left", 16'(fetch_q.size()), 16'h0);
        chk("data_q_left", 16'(data_q.size()), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
